// File: rtl/spi_reg_ctrl.sv
// Framed SPI register controller: 32-bit command frames commit one register atomically, with readback and status.
// Commit on the 32nd posedge of a frame; readback data on spi_miso from the 8th posedge on; no backpressure (host paced).
module spi_reg_ctrl #(
  parameter int N   = 18,
  parameter int L   = 12,
  parameter int D   = 5,
  parameter int F_S = 50000000,
  parameter int F_C = 10000000,
  parameter int DF  = 75000
) (
  input  logic         spi_clk,
  input  logic         rst,
  input  logic         spi_csn,
  input  logic         spi_mosi,
  output logic         spi_miso,
  input  logic         usb_i2sn_pin,
  input  logic         audio_chan_sel_pin,
  input  logic         i2s_ws_align_pin,
  input  logic         dith_disable_pin,
  output logic [N-1:0] acc_inc,
  output logic [L-1:0] df_inc,
  output logic [D-1:0] dac_ena,
  output logic [2:0]   dith_fact,
  output logic         usb_i2sn,
  output logic         audio_chan_sel,
  output logic         i2s_ws_align,
  output logic         cfg_seq
);

  localparam int ACC_RST = (2**N) / (F_S / F_C);
  localparam int DF_RST  = (2**N) / (F_S / DF);

  logic [5:0]  bit_cnt;
  logic        cnt_clr;
  logic [30:0] shift;
  logic [23:0] frame_dat;
  logic [23:0] rd_sr;
  logic [23:0] rd_val;
  logic        rd_phase;
  logic        pending;
  logic [7:0]  wr_cnt;
  logic [7:0]  err_cnt;
  logic [2:0]  dith;
  logic [3:0]  flags;
  logic        frame_en;

  // Deasserting chip select aborts the frame position immediately.
  assign cnt_clr = rst | spi_csn;

  always_ff @(posedge spi_clk or posedge cnt_clr) begin
    if (cnt_clr)
      bit_cnt <= 6'd0;
    else if (bit_cnt != 6'd32)
      bit_cnt <= bit_cnt + 6'd1;
  end

  assign frame_en  = !spi_csn && (bit_cnt != 6'd32);
  assign frame_dat = {shift[22:0], spi_mosi};

  // At the 8th edge shift[6] is R/Wn and shift[5:3] the address.
  always_comb begin
    rd_val = '0;
    case (shift[5:3])
      3'd0:    rd_val[N-1:0] = acc_inc;
      3'd1:    rd_val[L-1:0] = df_inc;
      3'd2:    rd_val[D-1:0] = dac_ena;
      3'd3:    rd_val[2:0]   = dith;
      3'd4:    rd_val[3:0]   = flags;
      3'd5:    rd_val        = {wr_cnt, err_cnt, 8'hA5};
      default: rd_val        = '0;
    endcase
  end

  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      shift    <= '0;
      rd_sr    <= '0;
      rd_phase <= 1'b0;
      pending  <= 1'b0;
      wr_cnt   <= '0;
      err_cnt  <= '0;
      cfg_seq  <= 1'b0;
      acc_inc  <= N'(ACC_RST);
      df_inc   <= L'(DF_RST);
      dac_ena  <= '1;
      dith     <= 3'd2;
      flags    <= '0;
    end else if (frame_en) begin
      shift <= {shift[29:0], spi_mosi};

      if (bit_cnt == 6'd0) begin
        rd_phase <= 1'b0;
        pending  <= 1'b1;
        if (pending && err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
      end

      if (bit_cnt == 6'd7) begin
        rd_phase <= shift[6];
        rd_sr    <= shift[6] ? rd_val : 24'd0;
      end else if (bit_cnt > 6'd7) begin
        rd_sr <= {rd_sr[22:0], 1'b0};
      end

      if (bit_cnt == 6'd31) begin
        pending <= 1'b0;
        if (!shift[30] && shift[29:27] <= 3'd4) begin
          case (shift[29:27])
            3'd0:    acc_inc <= frame_dat[N-1:0];
            3'd1:    df_inc  <= frame_dat[L-1:0];
            3'd2:    dac_ena <= frame_dat[D-1:0];
            3'd3:    dith    <= frame_dat[2:0];
            default: flags   <= frame_dat[3:0];
          endcase
          cfg_seq <= ~cfg_seq;
          wr_cnt  <= wr_cnt + 8'd1;
        end
      end
    end
  end

  assign spi_miso = !spi_csn && rd_phase && (bit_cnt >= 6'd8) && rd_sr[23];

  // Pins govern the mode flags until the host takes over via spi_override.
  always_comb begin
    usb_i2sn       = flags[3] ? flags[0] : usb_i2sn_pin;
    audio_chan_sel = flags[3] ? flags[1] : audio_chan_sel_pin;
    i2s_ws_align   = flags[3] ? flags[2] : i2s_ws_align_pin;
    dith_fact      = (!flags[3] && dith_disable_pin) ? 3'd0 : dith;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Addressed, framed SPI register controller for the FM transmitter configuration: acc_inc, df_inc, dac_ena, dith_fact and the mode flags.
- Replaces raw shift-through configuration with 32-bit command frames that commit one register atomically, so live outputs never toggle while bits are being shifted in.
- Supports readback of every register, and provides a status register and a commit toggle so the system clock domain can resynchronise updates.

Parameters:
N, 18, phase accumulator increment width
L, 12, frequency deviation increment width
D, 5, DAC enable width
F_S, 50000000, clock frequency (Hz) used for defaults
F_C, 10000000, default carrier (Hz)
DF, 75000, default deviation (Hz)

Ports:
spi_clk  in  1  SPI clock; all state on posedge
rst  in  1  asynchronous active-high reset
spi_csn  in  1  chip select, active low
spi_mosi  in  1  serial data in, MSB first
spi_miso  out  1  serial data out
usb_i2sn_pin  in  1  pin default for usb_i2sn
audio_chan_sel_pin  in  1  pin default for audio_chan_sel
i2s_ws_align_pin  in  1  pin default for i2s_ws_align
dith_disable_pin  in  1  forces dith_fact to 0 unless overridden
acc_inc  out  N  live register 0
df_inc  out  L  live register 1
dac_ena  out  D  live register 2
dith_fact  out  3  effective dither factor
usb_i2sn  out  1  effective flag
audio_chan_sel  out  1  effective flag
i2s_ws_align  out  1  effective flag
cfg_seq  out  1  toggles once per successful commit

Behaviour:
- Reset is rst: asynchronous, active-high. Clock is spi_clk.
- Reset values:
  - acc_inc = 2**N/(F_S/F_C), which is 52428 with the defaults.
  - df_inc = 2**N/(F_S/DF), integer division, which is 393 with the defaults.
  - dac_ena = all ones.
  - The dith register = 2.
  - FLAGS = 0.
  - cfg_seq = 0, wr_cnt = 0, err_cnt = 0, pending = 0, and the shift and read registers are 0.
- Frame format: exactly 32 bits while spi_csn is low.
  - Bit 31 is R/Wn (1 = read).
  - Bits 30:28 are the address.
  - Bits 27:24 are reserved and ignored.
  - Bits 23:0 are data.
- bit_cnt is 6 bits. It is asynchronously cleared by rst or by spi_csn high, and increments on each posedge while spi_csn is low. It saturates at 32.
- Address map:
  - 0 ACC_INC, R/W, data[N-1:0]
  - 1 DF_INC, R/W, data[L-1:0]
  - 2 DAC_ENA, R/W, data[D-1:0]
  - 3 DITH, R/W, data[2:0]
  - 4 FLAGS, R/W:
    - bit0 usb_i2sn
    - bit1 audio_chan_sel
    - bit2 i2s_ws_align
    - bit3 spi_override
  - 5 STATUS, RO: {wr_cnt[7:0], err_cnt[7:0], 8'hA5}
  - 6 and 7 are reserved: they read 0 and ignore writes.
- Write commit:
  - The commit happens on the posedge that clocks bit 32 (bit_cnt 31 to 32), and only for a write to address 0-4.
  - The target register loads the low bits of {shift[22:0], mosi}; upper data bits are discarded.
  - On the same edge, cfg_seq toggles and wr_cnt increments, wrapping at 8 bits.
  - A write to address 5-7 produces no commit, no toggle and no wr_cnt change.
- Read:
  - At the posedge that clocks bit 8 (bit_cnt 7 to 8), rd_sr[23:0] loads the zero-extended value of the addressed register.
  - rd_sr shifts left on each later posedge.
  - spi_miso = rd_sr[23] while the frame is active. It changes only after posedge; the host samples it on the following negedge.
  - Outside the data phase of a read, spi_miso = 0.
  - A read never modifies any register.
- Long frames: posedges beyond bit 32 are ignored, with no second commit, until spi_csn goes high.
- Short frames:
  - pending is set on the edge that clocks bit 1 of a frame and cleared on the bit-32 edge.
  - At the first edge of the next frame, if pending is still 1, err_cnt increments, saturating at 255.
  - A short frame is discarded and no register changes.
- Effective outputs:
  - usb_i2sn, audio_chan_sel and i2s_ws_align come from FLAGS when spi_override = 1, and from the corresponding pin otherwise.
  - dith_fact = 0 when spi_override = 0 and dith_disable_pin = 1; otherwise it is the DITH register.
  - These outputs are combinational from registers and pins.
- Reset mid-frame: all state returns to reset values immediately. The frame is lost, and it is not counted as an error.

Test Plan:
- Release reset, no SPI traffic -> acc_inc = 52428, df_inc = 393, dac_ena = 5'h1F, dith_fact = 2, flags follow the pins, cfg_seq = 0.
- Write addr 0 data 24'h012345 -> after the 32nd edge acc_inc = 18'h12345 and cfg_seq = 1. acc_inc stays unchanged at every earlier edge.
- Read addr 5 after one write -> spi_miso returns 24'h0100A5 MSB first. A subsequent read of addr 0 returns 24'h012345.
- 20-bit frame writing addr 1, then a full read of addr 5 -> df_inc unchanged, status = 24'h0101A5, cfg_seq not toggled.
- Write FLAGS = 4'b1001, with usb_i2sn_pin = 0 and dith_disable_pin = 1 -> usb_i2sn = 1 and dith_fact = 2. Then write FLAGS = 0 -> usb_i2sn = 0 and dith_fact = 0.
- Assert rst at bit 16 of a write -> all outputs return to defaults, and no commit occurs when the clocks resume.
